restoring_divider_param: RTL

- Parametrised multi-cycle restoring divider; successor to the fixed 16-bit signed divider in the Division library.
- Adds per-operation signed/unsigned mode, width parameter, Busy, a one-cycle Done pulse, and overflow and divide-by-zero status.
- Sits behind a register-mapped or ALU front end; one quotient bit per cycle; results held stable until the next accepted Start.

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_restore_step.sv | 24 ++
 rtl/restoring_divider_param.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider.
// Magnitude helpers operate on 64-bit sign-extended values.
package div_pkg;

  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WORK   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Absolute value of a sign-extended operand in signed mode.
  function automatic logic [MAXW-1:0] abs_mag(
    input logic [MAXW-1:0] value,
    input logic            signed_mode
  );
    return (signed_mode && value[MAXW-1]) ? -value : value;
  endfunction

  // Two's-complement negate when neg is set; -0 stays 0.
  function automatic logic [MAXW-1:0] cond_negate(
    input logic [MAXW-1:0] value,
    input logic            neg
  );
    return neg ? -value : value;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module div_restore_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   pr,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   pr_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtract; a clear sign bit means the divisor fits.
  always_comb begin
    shifted = {pr, dvd_bit};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[WIDTH+1];
    pr_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/restoring_divider_param.sv
// Multi-cycle restoring divider, signed/unsigned per operation.
// DIV_ZERO_FASTPATH_EN: zero divisor skips the iteration phase.
module restoring_divider_param
  import div_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed_Mode,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow,
  output logic             Div_By_Zero
);

  localparam logic [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] mq;
  logic             sign_q;
  logic             sign_r;
  logic             ov_q;
  logic             dz_q;

  logic [WIDTH:0]          pr_nx;
  logic                    q_bit;
  logic signed [WIDTH-1:0] dvd_s;
  logic signed [WIDTH-1:0] dvs_s;
  logic signed [MAXW-1:0]  dvd_x;
  logic signed [MAXW-1:0]  dvs_x;
  logic [MAXW-1:0]         dvd_m;
  logic [MAXW-1:0]         dvs_m;
  logic [MAXW-1:0]         q_fin;
  logic [MAXW-1:0]         r_fin;
  logic                    dvs_zero;

  assign dvd_s    = Dividend;
  assign dvs_s    = Divisor;
  assign dvd_x    = dvd_s;
  assign dvs_x    = dvs_s;
  assign dvd_m    = abs_mag(dvd_x, Signed_Mode);
  assign dvs_m    = abs_mag(dvs_x, Signed_Mode);
  assign q_fin    = cond_negate(MAXW'(mq), sign_q);
  assign r_fin    = cond_negate(MAXW'(pr[WIDTH-1:0]), sign_r);
  assign dvs_zero = (Divisor == '0);

  generate
    if (WIDTH < MAXW) begin : g_unused
      logic unused;
      assign unused = ^{dvd_m[MAXW-1:WIDTH],
                        dvs_m[MAXW-1:WIDTH],
                        q_fin[MAXW-1:WIDTH],
                        r_fin[MAXW-1:WIDTH]};
    end
  endgenerate

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .pr      (pr),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (dvs),
    .pr_next (pr_nx),
    .q_bit   (q_bit)
  );

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pr          <= '0;
      dvd         <= '0;
      dvs         <= '0;
      mq          <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      ov_q        <= 1'b0;
      dz_q        <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Overflow    <= 1'b0;
      Div_By_Zero <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            dvd         <= dvd_m[WIDTH-1:0];
            dvs         <= dvs_m[WIDTH-1:0];
            mq          <= '0;
            pr          <= '0;
            cnt         <= '0;
            sign_q      <= Signed_Mode &
                           (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
            sign_r      <= Signed_Mode & Dividend[WIDTH-1];
            ov_q        <= Signed_Mode & (Dividend == MIN) &
                           (&Divisor);
            dz_q        <= dvs_zero;
            Overflow    <= 1'b0;
            Div_By_Zero <= 1'b0;
            Busy        <= 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
            if (dvs_zero) begin
              mq    <= '1;
              pr    <= {1'b0, dvd_m[WIDTH-1:0]};
              state <= FINISH;
            end else begin
              state <= WORK;
            end
`else
            state <= WORK;
`endif
          end
        end
        WORK: begin
          pr  <= pr_nx;
          mq  <= {mq[WIDTH-2:0], q_bit};
          dvd <= dvd << 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          Quotient    <= q_fin[WIDTH-1:0];
          Remainder   <= r_fin[WIDTH-1:0];
          Overflow    <= ov_q;
          Div_By_Zero <= dz_q;
          Done        <= 1'b1;
          Busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
